// File: rtl/vadd_out_fifo_if.sv
// rtl/vadd_out_fifo_if.sv - chunk handshake bundle between vadd kernel, output FIFO and stream writer
// slave = FIFO side, master = kernel/consumer side.
interface vadd_out_fifo_if #(
  parameter int C_DATA_WIDTH = 512,
  parameter int DEPTH        = 16
);
  logic                    in_ready;
  logic                    in_avail;
  logic [C_DATA_WIDTH-1:0] in_data;
  logic                    out_ready;
  logic                    out_avail;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic                    out_last;
  logic [$clog2(DEPTH):0]  level;

  modport slave (
    output in_ready,
    input  in_avail,
    input  in_data,
    input  out_ready,
    output out_avail,
    output out_data,
    output out_last,
    output level
  );

  modport master (
    input  in_ready,
    output in_avail,
    output in_data,
    output out_ready,
    input  out_avail,
    input  out_data,
    input  out_last,
    input  level
  );
endinterface

// File: rtl/vadd_out_fifo.sv
// rtl/vadd_out_fifo.sv - output chunk FIFO for the vadd kernel with end-of-sequence tagging
// Optional debug counters are enabled by defining VADD_OUT_FIFO_STATS_EN.
module vadd_out_fifo #(
  parameter int C_DATA_WIDTH = 512,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VADD_OUT_FIFO_STATS_EN
  input  logic                   stat_clear,
  output logic [31:0]            stat_words,
  output logic [15:0]            stat_bursts,
  output logic [$clog2(DEPTH):0] stat_max_level,
`endif
  vadd_out_fifo_if.slave         bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [C_DATA_WIDTH-1:0] EMPTY_PATTERN = {(C_DATA_WIDTH/8){8'h0F}};

  logic [C_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level_q;
  logic [LW-1:0]           level_nxt;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic                    full;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);

  // No full pass-through and no empty bypass: both flags come from the registered level only.
  assign bus.in_ready  = reset && !full;
  assign bus.out_avail = !empty;
  assign push          = reset && !full && bus.in_avail;
  assign pop           = !empty && bus.out_ready;

  assign bus.out_data = empty ? EMPTY_PATTERN : mem[rd_ptr];
  assign bus.out_last = !empty && (mem[rd_ptr][7:0] == 8'h00);
  assign bus.level    = level_q;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_nxt;
    end
  end

  // Storage carries no reset; validity is tracked solely by level_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

`ifdef VADD_OUT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words     <= '0;
      stat_bursts    <= '0;
      stat_max_level <= '0;
    end else if (stat_clear) begin
      stat_words     <= '0;
      stat_bursts    <= '0;
      stat_max_level <= '0;
    end else begin
      if (pop && (stat_words != '1))                  stat_words  <= stat_words + 1'b1;
      if (pop && bus.out_last && (stat_bursts != '1)) stat_bursts <= stat_bursts + 1'b1;
      if (level_nxt > stat_max_level)                 stat_max_level <= level_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_vadd_out_fifo.sv
// tb/tb_vadd_out_fifo.sv - randomized self-checking bench for vadd_out_fifo against a queue model
module tb_vadd_out_fifo;
  localparam int DW    = 512;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vadd_out_fifo_if #(.C_DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

`ifdef VADD_OUT_FIFO_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_words;
  logic [15:0]   stat_bursts;
  logic [LW-1:0] stat_max_level;
`endif

  vadd_out_fifo #(.C_DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef VADD_OUT_FIFO_STATS_EN
    .stat_clear     (stat_clear),
    .stat_words     (stat_words),
    .stat_bursts    (stat_bursts),
    .stat_max_level (stat_max_level),
`endif
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] pat = {(DW/8){8'h0F}};
  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  int            pops_total = 0;
  bit            last_push  = 1'b0;
  bit            m_push;
  bit            m_pop;
  int            m_words  = 0;
  int            m_bursts = 0;
  int            m_max    = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue; pops take from the pre-edge contents, pushes only when not full pre-edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      last_push = 1'b0;
      m_words = 0; m_bursts = 0; m_max = 0;
    end else begin
      m_push = bus.in_avail && (q.size() < DEPTH);
      m_pop  = bus.out_ready && (q.size() > 0);
      if (m_pop) begin
        pops_total++;
        m_words++;
        if (q[0][7:0] == 8'h00) m_bursts++;
        popped.push_back(q[0]);
        void'(q.pop_front());
      end
      if (m_push) q.push_back(bus.in_data);
      last_push = m_push;
      if (q.size() > m_max) m_max = q.size();
`ifdef VADD_OUT_FIFO_STATS_EN
      if (stat_clear) begin
        m_words = 0; m_bursts = 0; m_max = 0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  DW'(bus.in_ready),  DW'(reset && (q.size() != DEPTH)));
      chk("out_avail", DW'(bus.out_avail), DW'(q.size() != 0));
      chk("out_data",  bus.out_data,       (q.size() != 0) ? q[0] : pat);
      chk("out_last",  DW'(bus.out_last),  DW'((q.size() != 0) && (q[0][7:0] == 8'h00)));
      chk("level",     DW'(bus.level),     DW'(q.size()));
`ifdef VADD_OUT_FIFO_STATS_EN
      chk("stat_words",     DW'(stat_words),     DW'(m_words));
      chk("stat_bursts",    DW'(stat_bursts),    DW'(m_bursts));
      chk("stat_max_level", DW'(stat_max_level), DW'(m_max));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_chunk(input logic [7:0] lb);
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
    r[7:0] = lb;
    return r;
  endfunction

  task automatic push_chunk(input logic [DW-1:0] d);
    int budget;
    bus.in_avail = 1'b1;
    bus.in_data  = d;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!last_push && budget < 50);
    if (!last_push) chk("push_timeout", 0, 1);
    bus.in_avail = 1'b0;
  endtask

  task automatic drain();
    int budget;
    bus.in_avail  = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    chk("drain_level", DW'(bus.level), 0);
  endtask

  logic [DW-1:0] marker;
  int            start_pops;
  int            budget;

  initial begin
    bus.in_avail  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    chk("rst_in_ready",  DW'(bus.in_ready),  0);
    chk("rst_out_avail", DW'(bus.out_avail), 0);
    chk("rst_out_data",  bus.out_data,       {(DW/8){8'h0F}});
    chk("rst_level",     DW'(bus.level),     0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  DW'(bus.in_ready),  1);
    chk("rel_out_avail", DW'(bus.out_avail), 0);
    chk("rel_out_data",  bus.out_data,       {(DW/8){8'h0F}});
    #1;

    // Fill past capacity with the consumer stalled.
    for (int i = 0; i < 16; i++) push_chunk(rand_chunk(8'(8'h10 - i)));
    bus.in_avail = 1'b1;
    bus.in_data  = rand_chunk(8'h00);
    repeat (3) step();
    chk("full_level",    DW'(bus.level),    16);
    chk("full_in_ready", DW'(bus.in_ready), 0);
    chk("held_no_push",  DW'(last_push),    0);
    popped.delete();
    start_pops = pops_total;
    bus.out_ready = 1'b1;
    step();
    chk("first_pop_in_ready", DW'(bus.in_ready), 1);
    budget = 0;
    while (pops_total - start_pops < 17 && budget < 60) begin
      if (last_push) bus.in_avail = 1'b0;
      if (pops_total - start_pops == 16) begin
        chk("tail_out_last", DW'(bus.out_last), 1);
        chk("tail_low_byte", DW'(bus.out_data[7:0]), 0);
      end
      step();
      budget++;
    end
    bus.in_avail = 1'b0;
    chk("drain17_count", DW'(popped.size()), 17);
    if (popped.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("order_lb", DW'(popped[i][7:0]), DW'(8'h10 - i));
      chk("order_last_lb", DW'(popped[16][7:0]), 0);
    end
    drain();

    // Steady state at level 3: every cycle pushes and pops.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_chunk(rand_chunk(8'($urandom_range(1, 255))));
    bus.in_avail  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.in_data = rand_chunk(8'($urandom));
      step();
      chk("steady_level", DW'(bus.level), 3);
      chk("steady_push",  DW'(last_push), 1);
    end
    drain();

    // Asynchronous reset while holding 8 entries.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_chunk(rand_chunk(8'h55));
    chk("pre_rst_level", DW'(bus.level), 8);
    #2 reset = 1'b0;
    #1;
    chk("async_level",     DW'(bus.level),     0);
    chk("async_out_avail", DW'(bus.out_avail), 0);
    chk("async_in_ready",  DW'(bus.in_ready),  0);
    step();
    reset = 1'b1;
    marker = rand_chunk(8'hA7);
    popped.delete();
    bus.out_ready = 1'b1;
    push_chunk(marker);
    step();
    chk("post_rst_first", (popped.size() > 0) ? popped[0] : '0, marker);
    drain();

    // Randomized traffic; the producer holds an offered chunk until it is taken.
    for (int c = 0; c < 600; c++) begin
      if (!bus.in_avail || last_push) begin
        bus.in_avail = ($urandom_range(0, 3) != 0);
        bus.in_data  = rand_chunk(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      end
      bus.out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

`ifdef VADD_OUT_FIFO_STATS_EN
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 5; j++) push_chunk(rand_chunk((j == 4) ? 8'h00 : 8'(8'h20 + j)));
    drain();
    step();
    chk("stat_words_15",  DW'(stat_words),     15);
    chk("stat_bursts_3",  DW'(stat_bursts),    3);
    chk("stat_max_1",     DW'(stat_max_level), 1);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("clr_words",  DW'(stat_words),     0);
    chk("clr_bursts", DW'(stat_bursts),    0);
    chk("clr_max",    DW'(stat_max_level), 0);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1);
  end
endmodule
